// File: rtl/eth_frame_tx.sv
// Repeating frame transmitter: streams a RAM-held frame template onto an AXI4-Stream master,
// with a programmable inter-frame gap, abort truncation, start timestamps and a frame counter.
module eth_frame_tx #(
  parameter int unsigned mem_addr_width = 11,
  parameter int unsigned gap_width      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      abort,
  input  logic [15:0]               frame_size,
  input  logic [gap_width-1:0]      frame_gap,
  output logic [mem_addr_width-1:0] mem_addr,
  input  logic [7:0]                mem_rdata,
  output logic [7:0]                m_axis_tdata,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic [63:0]               current_time,
  input  logic                      time_running,
  output logic [63:0]               tx_timestamp,
  output logic                      tx_done,
  output logic [63:0]               tx_count
);

  localparam int unsigned SizeW   = mem_addr_width + 1;
  localparam int unsigned MaxSize = 2 ** mem_addr_width;
  localparam int unsigned MinSize = 60;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  state_t state, state_next;

  logic [SizeW-1:0]          size_q, size_new;
  logic [gap_width-1:0]      gap_q, gap_cnt;
  logic [mem_addr_width-1:0] rd_cnt;
  logic                      rd_done_q;
  logic                      pend_q, pend_last_q;
  logic                      abort_q;
  logic                      first_q;
  logic                      valid_q;
  beat_t                     fifo_q [2];
  logic [1:0]                cnt_q;

  logic   start, can_start, pop, tlast_hs, ab_now, keep, marked, issue;
  logic [1:0] occ, total, cnt_next;
  beat_t  push_beat;
  beat_t  lst [3];
  beat_t  fifo_next [2];

  assign can_start = enable & time_running;
  assign pop       = valid_q & m_axis_tready;
  assign tlast_hs  = pop & fifo_q[0].last;

  assign mem_addr      = rd_cnt;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = fifo_q[0].data;
  assign m_axis_tlast  = fifo_q[0].last;
  assign m_axis_tuser  = fifo_q[0].user;

  // Frame length clamp applied when a frame is started
  always_comb begin
    size_new = SizeW'(frame_size);
    if (32'(frame_size) < MinSize)      size_new = SizeW'(MinSize);
    else if (32'(frame_size) > MaxSize) size_new = SizeW'(MaxSize);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The start cycle doubles as the address cycle for byte 0
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: if (can_start) begin
        start      = 1'b1;
        state_next = SEND;
      end
      SEND: if (tlast_hs) begin
        if (gap_q != '0)    state_next = GAP;
        else if (can_start) start      = 1'b1;
        else                state_next = IDLE;
      end
      GAP: if (gap_cnt >= gap_q) begin
        if (can_start) begin
          start      = 1'b1;
          state_next = SEND;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output FIFO update; an abort marks the first byte not yet visible on the bus and drops the rest
  always_comb begin
    push_beat = {mem_rdata, pend_last_q, 1'b0};
    occ       = cnt_q - 2'(pop);
    total     = occ + 2'(pend_q);
    lst[0]    = pop ? fifo_q[1] : fifo_q[0];
    lst[1]    = fifo_q[1];
    lst[2]    = push_beat;
    if (pend_q) begin
      case (occ)
        2'd0:    lst[0] = push_beat;
        2'd1:    lst[1] = push_beat;
        default: lst[2] = push_beat;
      endcase
    end
    ab_now       = (state == SEND) & ~tlast_hs & (abort_q | abort);
    keep         = ~pop & valid_q;
    fifo_next[0] = lst[0];
    fifo_next[1] = lst[1];
    cnt_next     = total;
    marked       = 1'b0;
    if (ab_now) begin
      if (keep && fifo_q[0].last) begin
        cnt_next = 2'd1;
        marked   = 1'b1;
      end else if (total > 2'(keep)) begin
        if (keep) begin
          fifo_next[1].last = 1'b1;
          fifo_next[1].user = 1'b1;
          cnt_next          = 2'd2;
        end else begin
          fifo_next[0].last = 1'b1;
          fifo_next[0].user = 1'b1;
          cnt_next          = 2'd1;
        end
        marked = 1'b1;
      end
    end
    issue = (state == SEND) & ~rd_done_q & (total < 2'd2) & ~marked;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      rd_cnt       <= '0;
      rd_done_q    <= 1'b0;
      size_q       <= '0;
      gap_q        <= '0;
      gap_cnt      <= '0;
      abort_q      <= 1'b0;
      first_q      <= 1'b0;
      tx_timestamp <= '0;
      tx_done      <= 1'b0;
      tx_count     <= '0;
    end else begin
      fifo_q[0] <= fifo_next[0];
      fifo_q[1] <= fifo_next[1];
      cnt_q     <= cnt_next;
      valid_q   <= (cnt_next != 2'd0);
      pend_q    <= start | issue;

      if (start) begin
        size_q      <= size_new;
        gap_q       <= frame_gap;
        rd_cnt      <= mem_addr_width'(1);
        rd_done_q   <= 1'b0;
        pend_last_q <= 1'b0;
        abort_q     <= 1'b0;
      end else begin
        if (issue) begin
          pend_last_q <= ({1'b0, rd_cnt} == size_q - SizeW'(1));
          if ({1'b0, rd_cnt} == size_q - SizeW'(1)) begin
            rd_cnt    <= '0;
            rd_done_q <= 1'b1;
          end else begin
            rd_cnt <= rd_cnt + mem_addr_width'(1);
          end
        end
        if (marked) begin
          rd_cnt    <= '0;
          rd_done_q <= 1'b1;
          abort_q   <= 1'b0;
        end else if (ab_now) begin
          abort_q <= 1'b1;
        end
      end

      if (state == SEND && tlast_hs) gap_cnt <= gap_width'(1);
      else if (state == GAP)         gap_cnt <= gap_cnt + gap_width'(1);

      if (pop && first_q) tx_timestamp <= current_time;
      if (pop)   first_q <= 1'b0;
      if (start) first_q <= 1'b1;

      tx_done <= tlast_hs;
      if (tlast_hs) tx_count <= tx_count + 64'd1;
    end
  end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx: expected beats are queued as frames are launched and
// compared at every handshake, alongside AXIS hold rules, gap timing and timestamps.
module tb_eth_frame_tx;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, abort, m_axis_tready, time_running;
  logic [15:0] frame_size;
  logic [31:0] frame_gap;
  logic [10:0] mem_addr;
  logic [7:0]  mem_rdata = 8'd0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tuser, m_axis_tlast, m_axis_tvalid;
  logic [63:0] current_time, tx_timestamp, tx_count;
  logic        tx_done;

  logic [7:0]  ram [2048];
  longint      cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  beat_t       exp_q [$];
  int          beat_idx = 0;
  longint      first_cyc = 0, last_cyc = 0, gap_meas = 0, en_cyc = 0;

  eth_frame_tx dut (
    .clk(clk), .rst(rst), .enable(enable), .abort(abort),
    .frame_size(frame_size), .frame_gap(frame_gap),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .current_time(current_time), .time_running(time_running),
    .tx_timestamp(tx_timestamp), .tx_done(tx_done), .tx_count(tx_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rdata <= ram[mem_addr];
  assign current_time = 64'd1000 + 64'(cyc);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = 8'(i);
      b.last = (i == n - 1);
      b.user = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_frames(input logic [63:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (tx_count != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, tx_count, target);
  endtask

  task automatic wait_started(input int budget, input string tag);
    int n;
    n = 0;
    while (beat_idx == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(beat_idx != 0), 64'd1);
  endtask

  // Scoreboard and AXIS protocol monitor
  initial begin
    logic  prev_valid, prev_ready, prev_hs_last, hs;
    beat_t prev_beat, got, exp;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_hs_last = 1'b0; prev_beat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0; prev_hs_last = 1'b0; beat_idx = 0;
      end else begin
        got = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        if (prev_valid && !prev_ready) begin
          check("hold_valid", 64'(m_axis_tvalid), 64'd1);
          check("hold_beat", 64'(got), 64'(prev_beat));
        end
        if (tx_done || prev_hs_last) check("tx_done", 64'(tx_done), 64'(prev_hs_last));
        hs = m_axis_tvalid && m_axis_tready;
        if (hs) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 64'(exp_q.size()), 64'd1);
          end else begin
            exp = exp_q.pop_front();
            check("beat", 64'(got), 64'(exp));
          end
          if (beat_idx == 0) begin
            first_cyc = cyc;
            gap_meas  = cyc - last_cyc;
          end
          beat_idx++;
          if (m_axis_tlast) begin
            last_cyc = cyc;
            beat_idx = 0;
          end
        end
        prev_valid = m_axis_tvalid; prev_ready = m_axis_tready;
        prev_beat = got; prev_hs_last = hs && m_axis_tlast;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic found;
    for (int i = 0; i < 2048; i++) ram[i] = 8'(i);
    rst = 1'b1; enable = 1'b0; abort = 1'b0; m_axis_tready = 1'b1; time_running = 1'b1;
    frame_size = 16'd64; frame_gap = 32'd10;
    repeat (3) step();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tuser", 64'(m_axis_tuser), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_count", tx_count, 64'd0);
    check("rst_ts", tx_timestamp, 64'd0);
    check("rst_done", 64'(tx_done), 64'd0);
    rst = 1'b0;
    step();

    // Two 64-byte frames, gap 10
    push_frame(64); push_frame(64);
    enable = 1'b1; en_cyc = cyc;
    wait_frames(64'd1, 200, "frame1_done");
    check("first_latency", 64'(first_cyc - en_cyc), 64'd2);
    wait_started(40, "frame2_start");
    step(); enable = 1'b0;
    wait_frames(64'd2, 200, "frame2_done");
    check("gap10_spacing", 64'(gap_meas), 64'd12);
    check("sb_empty_t1", 64'(exp_q.size()), 64'd0);
    repeat (16) step();

    // Length clamping, low and high
    frame_size = 16'd20; frame_gap = 32'd0; push_frame(60);
    enable = 1'b1; step(); enable = 1'b0;
    wait_frames(64'd3, 200, "clamp60_done");
    repeat (4) step();
    frame_size = 16'd4000; push_frame(2048);
    enable = 1'b1; step(); enable = 1'b0;
    wait_frames(64'd4, 2300, "clamp2048_done");
    check("sb_empty_t2", 64'(exp_q.size()), 64'd0);
    repeat (4) step();

    // Random backpressure on a 100-byte frame
    frame_size = 16'd100; push_frame(100);
    enable = 1'b1; step(); enable = 1'b0;
    n = 0;
    while (tx_count != 64'd5 && n < 2000) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    m_axis_tready = 1'b1;
    check("random_ready_done", tx_count, 64'd5);
    check("sb_empty_t3", 64'(exp_q.size()), 64'd0);
    repeat (4) step();

    // Abort at beat 30, follow-on frame after a 5-cycle gap
    frame_gap = 32'd5; push_frame(100);
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tdata == 8'd30) found = 1'b1;
    end
    check("reach_beat30", 64'(found), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    if (exp_q.size() == 1) begin
      exp_q[0].last = 1'b1;
      exp_q[0].user = 1'b1;
    end
    push_frame(100);
    wait_frames(64'd6, 50, "abort_done");
    wait_started(40, "after_abort_start");
    step(); enable = 1'b0;
    check("abort_gap_spacing", 64'(gap_meas), 64'd7);
    wait_frames(64'd7, 300, "after_abort_done");
    check("sb_empty_t4", 64'(exp_q.size()), 64'd0);
    repeat (10) step();

    // Timestamp at first handshake, not at tvalid rise
    frame_size = 16'd60; frame_gap = 32'd0; push_frame(60);
    m_axis_tready = 1'b0; enable = 1'b1; en_cyc = cyc;
    step(); enable = 1'b0;
    repeat (4) step();
    m_axis_tready = 1'b1;
    wait_frames(64'd8, 200, "ts_frame_done");
    check("ts_first_cyc", 64'(first_cyc - en_cyc), 64'd5);
    check("ts_value", tx_timestamp, 64'd1000 + 64'(en_cyc) + 64'd5);
    repeat (4) step();

    // Timer stopped blocks frame start
    time_running = 1'b0; enable = 1'b1;
    repeat (10) step();
    check("stopped_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("stopped_count", tx_count, 64'd8);
    enable = 1'b0; time_running = 1'b1;
    step();

    // Reset mid-frame, then restart with enable held
    frame_size = 16'd100; frame_gap = 32'd3; push_frame(100);
    enable = 1'b1; step(); enable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tdata == 8'd20) found = 1'b1;
    end
    check("reach_beat20", 64'(found), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_tlast", 64'(m_axis_tlast), 64'd0);
    check("midrst_count", tx_count, 64'd0);
    check("midrst_addr", 64'(mem_addr), 64'd0);
    exp_q.delete();
    step();
    push_frame(100);
    enable = 1'b1;
    rst = 1'b0;
    step(); enable = 1'b0;
    wait_frames(64'd1, 300, "post_rst_done");
    check("sb_empty_t6", 64'(exp_q.size()), 64'd0);
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
